// File: rtl/bounce_gen.sv
// bounce_gen: turns a clean press/release level into a contact-bounce
// waveform with LFSR-randomised glitch dwell times for the debouncer.
//
// Ports:
//   CLK50M  : system clock
//   RESET_N : asynchronous active-low reset
//   press   : clean requested button level (synchronous to CLK50M)
//   A_noisy : bouncing button level toward the debouncer
//   busy    : high while a transition is emitted (BOUNCE or SETTLE)
//   done    : one-cycle pulse when a transition completes
module bounce_gen #(
  parameter int          BOUNCE_COUNT  = 3,
  parameter int          MIN_DWELL     = 4,
  parameter int          SPAN_BITS     = 2,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic CLK50M,
  input  logic RESET_N,
  input  logic press,
  output logic A_noisy,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_t;

  // Galois feedback for x^16 + x^14 + x^13 + x^11
  localparam logic [15:0] TAPS = 16'hB400;

  state_t      state;
  logic        target;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [15:0] cnt;
  logic [15:0] dwell;
  logic [3:0]  pulses_left;

  assign lfsr_nxt = {1'b0, lfsr[15:1]}
                  ^ (lfsr[0] ? TAPS : 16'h0000);

  assign dwell = 16'(MIN_DWELL)
               + 16'(lfsr[SPAN_BITS-1:0]);

  always_ff @(posedge CLK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      target      <= 1'b0;
      A_noisy     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lfsr        <= LFSR_SEED;
      cnt         <= '0;
      pulses_left <= '0;
    end else begin
      lfsr <= lfsr_nxt;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press != target) begin
            target      <= press;
            A_noisy     <= press;
            busy        <= 1'b1;
            pulses_left <= 4'(BOUNCE_COUNT);
            if (BOUNCE_COUNT == 0) begin
              cnt   <= 16'(SETTLE_CYCLES);
              state <= SETTLE;
            end else begin
              cnt   <= dwell;
              state <= BOUNCE;
            end
          end
        end
        BOUNCE: begin
          if (cnt == 16'd1) begin
            A_noisy <= ~A_noisy;
            // Toggling from ~target back to target ends one glitch
            if (A_noisy != target) begin
              pulses_left <= pulses_left - 4'd1;
              if (pulses_left == 4'd1) begin
                cnt   <= 16'(SETTLE_CYCLES);
                state <= SETTLE;
              end else begin
                cnt <= dwell;
              end
            end else begin
              cnt <= dwell;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        SETTLE: begin
          if (cnt == 16'd1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed self-checking bench for bounce_gen.
// Edge timing is checked against a reference LFSR sequence.
`timescale 1ns/1ps
module tb_bounce_gen;

  localparam int MIN_DW  = 4;
  localparam int SETTLE  = 16;
  localparam int SETTLE0 = 5;
  localparam int DB_N    = 10;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic press  = 1'b0;
  logic press0 = 1'b0;
  logic a_noisy, busy, done;
  logic a0, busy0, done0;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  bounce_gen u_dut (
    .CLK50M  (clk),
    .RESET_N (rst_n),
    .press   (press),
    .A_noisy (a_noisy),
    .busy    (busy),
    .done    (done)
  );

  bounce_gen #(
    .BOUNCE_COUNT  (0),
    .SETTLE_CYCLES (SETTLE0)
  ) u_zero (
    .CLK50M  (clk),
    .RESET_N (rst_n),
    .press   (press0),
    .A_noisy (a0),
    .busy    (busy0),
    .done    (done0)
  );

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] v
  );
    return {1'b0, v[15:1]}
         ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  logic db_out;
  int   db_cnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      db_out <= 1'b0;
      db_cnt <= 0;
    end else if (a_noisy != db_out) begin
      if (db_cnt == DB_N - 1) begin
        db_out <= a_noisy;
        db_cnt <= 0;
      end else begin
        db_cnt <= db_cnt + 1;
      end
    end else begin
      db_cnt <= 0;
    end

  int   e_cyc[$];
  int   e_dw[$];
  logic e_lv[$];
  int   d_cyc[$];
  logic d_busy[$];
  logic d_lv[$];
  logic a_last  = 1'b0;
  logic db_last = 1'b0;
  int   db_rise = 0;
  int   db_fall = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_last  = 1'b0;
      db_last = 1'b0;
    end else begin
      if (a_noisy !== a_last) begin
        e_cyc.push_back(cyc);
        e_dw.push_back(MIN_DW + int'(m_prev[1:0]));
        e_lv.push_back(a_noisy);
      end
      a_last = a_noisy;
      if (done) begin
        d_cyc.push_back(cyc);
        d_busy.push_back(busy);
        d_lv.push_back(a_noisy);
      end
      if (db_out && !db_last) db_rise++;
      if (!db_out && db_last) db_fall++;
      db_last = db_out;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic clr();
    e_cyc.delete();
    e_dw.delete();
    e_lv.delete();
    d_cyc.delete();
    d_busy.delete();
    d_lv.delete();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    press  = 1'b0;
    press0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clr();
  endtask

  task automatic wait_done(input int n, input string tag);
    int k = 0;
    while (d_cyc.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (d_cyc.size() < n)
      chk({tag, "_done_timeout"}, d_cyc.size(), n);
  endtask

  task automatic wait_edges(input int n, input string tag);
    int k = 0;
    while (e_cyc.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (e_cyc.size() < n)
      chk({tag, "_edge_timeout"}, e_cyc.size(), n);
  endtask

  task automatic check_xfer(
    input string tag,
    input int    s,
    input int    d,
    input int    n,
    input logic  lvl
  );
    int cnt = 0;
    if (d_cyc.size() <= d) return;
    for (int i = s; i < e_cyc.size(); i++)
      if (e_cyc[i] <= d_cyc[d]) cnt++;
    chk({tag, "_edges"}, cnt, n);
    if (cnt == n) begin
      for (int i = s; i < s + n - 1; i++) begin
        int iv = e_cyc[i+1] - e_cyc[i];
        chk({tag, "_dwell"}, iv, e_dw[i]);
        chk({tag, "_dwell_rng"},
            32'(iv >= MIN_DW && iv <= MIN_DW + 3), 1);
      end
      chk({tag, "_settle"},
          d_cyc[d] - e_cyc[s+n-1], SETTLE);
      chk({tag, "_level"}, e_lv[s+n-1], lvl);
    end
    chk({tag, "_done_busy"}, d_busy[d], 0);
    chk({tag, "_done_lvl"}, d_lv[d], lvl);
  endtask

  int   ra[$];
  int   ra_done;
  int   c;
  logic pre;
  int   z_edges;
  int   z_edge;
  int   z_done;
  logic zl;

  initial begin
    // Reset values and idle with press low
    repeat (3) @(negedge clk);
    chk("rst_a", a_noisy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clr();
    repeat (50) @(negedge clk);
    chk("idle_edges", e_cyc.size(), 0);
    chk("idle_done", d_cyc.size(), 0);
    chk("idle_a", a_noisy, 0);
    chk("idle_busy", busy, 0);

    // Undisturbed press then release
    do_reset();
    repeat (10) @(posedge clk);
    #1 c = cyc;
    press = 1'b1;
    chk("pre_edge_a", a_noisy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("start_a", a_noisy, 1);
    chk("start_busy", busy, 1);
    wait_done(1, "rise");
    if (e_cyc.size() > 0)
      chk("first_edge_cyc", e_cyc[0], c + 1);
    check_xfer("rise", 0, 0, 7, 1'b1);
    ra = e_cyc;
    ra_done = (d_cyc.size() > 0) ? d_cyc[0] : -1;
    repeat (3) @(negedge clk);
    chk("single_done", d_cyc.size(), 1);
    @(posedge clk);
    #1 press = 1'b0;
    wait_done(2, "fall");
    check_xfer("fall", 7, 1, 7, 1'b0);

    // Same seed, press glitch during BOUNCE, release held at done
    do_reset();
    repeat (10) @(posedge clk);
    #1 press = 1'b1;
    repeat (4) @(posedge clk);
    #1 press = 1'b0;
    @(posedge clk);
    #1 press = 1'b1;
    wait_edges(7, "det");
    press = 1'b0;
    wait_done(1, "det");
    if (e_cyc.size() >= 7 && ra.size() >= 7)
      for (int i = 0; i < 7; i++)
        chk("det_edge_cyc", e_cyc[i], ra[i]);
    if (d_cyc.size() > 0)
      chk("det_done_cyc", d_cyc[0], ra_done);
    wait_done(2, "refall");
    if (e_cyc.size() > 7 && d_cyc.size() > 0)
      chk("b2b_start", e_cyc[7], d_cyc[0] + 1);
    check_xfer("refall", 7, 1, 7, 1'b0);

    // Asynchronous reset during the 3rd glitch of a release
    do_reset();
    @(posedge clk);
    #1 press = 1'b1;
    wait_done(1, "rst_rise");
    clr();
    @(posedge clk);
    #1 press = 1'b0;
    wait_edges(6, "rst_wait");
    #2 pre = a_noisy;
    chk("pre_rst_a", pre, 1);
    rst_n = 1'b0;
    #1;
    chk("async_a", a_noisy, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_no_done", d_cyc.size(), 0);
    chk("rst_no_edges", e_cyc.size(), 6);

    // Zero-bounce instance: one clean edge, done 5 later
    do_reset();
    repeat (5) @(posedge clk);
    #1 c = cyc;
    press0  = 1'b1;
    z_edges = 0;
    z_edge  = -1;
    z_done  = -1;
    zl      = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (a0 !== zl) begin
        z_edges++;
        z_edge = cyc;
      end
      zl = a0;
      if (done0 && z_done < 0) z_done = cyc;
    end
    chk("zero_edges", z_edges, 1);
    chk("zero_edge_cyc", z_edge, c + 1);
    chk("zero_done_gap", z_done - z_edge, SETTLE0);
    chk("zero_final_a", a0, 1);
    chk("zero_busy", busy0, 0);

    // Loopback into a simple debouncer
    do_reset();
    db_rise = 0;
    db_fall = 0;
    @(posedge clk);
    #1 press = 1'b1;
    wait_done(1, "lb_rise");
    @(posedge clk);
    #1 press = 1'b0;
    wait_done(2, "lb_fall");
    repeat (5) @(negedge clk);
    chk("lb_rises", db_rise, 1);
    chk("lb_falls", db_fall, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
